reg_ul_bank_mc: RTL and testbench



---
 rtl/reg_ul_bank_mc.sv | 189 ++++++++++++++++++
 tb/tb_reg_ul_bank_mc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_ul_bank_mc.sv
// reg_ul_bank_mc: multi-channel user-logic register bank on the MPI register bus.
// Holds version/ID, vled, timeout config, scratch and read-counter test registers,
// plus NUM_CH adder channels with sticky W1C error flags and saturating counters.
// Optional build macro: REG_UL_WR_PROTECT_EN adds a key register at 0x00F that
// gates channel writes.
// Ports:
//   clks, reset        register clock, async active-high reset
//   cpu_wr, cpu_rd     one-cycle write / read strobes
//   cpu_wr_addr        word address shared by reads and writes
//   cpu_data_in        write data
//   cpu_data_out       registered read data, held until the next read
//   cpu_rd_vld         one-cycle read-data-valid pulse
//   ul2sh_vled         virtual LED register
//   reg_tmout_us_cfg   timeout config register
//   err_in             per-channel error pulses, channel c at [c*ERR_WIDTH +: ERR_WIDTH]
module reg_ul_bank_mc #(
    parameter int unsigned CPU_ADDR_WIDTH = 12,
    parameter int unsigned CPU_DATA_WIDTH = 32,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned ERR_WIDTH      = 2,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter logic [31:0] VER_TIME       = 32'h2018_0301,
    parameter logic [31:0] VER_TYPE       = 32'h00D3_0007
) (
    input  logic                          clks,
    input  logic                          reset,
    input  logic                          cpu_wr,
    input  logic [CPU_ADDR_WIDTH-1:0]     cpu_wr_addr,
    input  logic [CPU_DATA_WIDTH-1:0]     cpu_data_in,
    input  logic                          cpu_rd,
    output logic [CPU_DATA_WIDTH-1:0]     cpu_data_out,
    output logic                          cpu_rd_vld,
    output logic [15:0]                   ul2sh_vled,
    output logic [15:0]                   reg_tmout_us_cfg,
    input  logic [NUM_CH*ERR_WIDTH-1:0]   err_in
);

    localparam int unsigned AW = CPU_ADDR_WIDTH;
    localparam int unsigned DW = CPU_DATA_WIDTH;
    localparam int unsigned GW = AW - 2;

    localparam logic [AW-1:0] A_VER_TIME = AW'(32'h000);
    localparam logic [AW-1:0] A_VER_TYPE = AW'(32'h001);
    localparam logic [AW-1:0] A_VLED     = AW'(32'h002);
    localparam logic [AW-1:0] A_TMOUT    = AW'(32'h003);
    localparam logic [AW-1:0] A_SCRATCH  = AW'(32'h004);
    localparam logic [AW-1:0] A_RD_CNT   = AW'(32'h005);
    localparam logic [AW-1:0] A_NUM_CH   = AW'(32'h006);

    logic [DW-1:0]     scratch;
    logic [DW-1:0]     rd_cnt;
    logic              wr_unlock_c;
    logic [NUM_CH-1:0] ch_hit_c;
    logic [DW-1:0]     ch_rd_c [NUM_CH];
    logic [DW-1:0]     rd_data_c;

`ifdef REG_UL_WR_PROTECT_EN
    localparam logic [AW-1:0] A_KEY     = AW'(32'h00F);
    localparam logic [DW-1:0] UNLOCK_KEY = DW'(32'h5A5A_A5A5);
    logic [DW-1:0] key;
    assign wr_unlock_c = (key == UNLOCK_KEY);
`else
    assign wr_unlock_c = 1'b1;
`endif

    // Channel c occupies the 4-word group starting at 0x010 + 4*c
    always_comb begin
        ch_hit_c = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            ch_hit_c[c] = (cpu_wr_addr[AW-1:2] == GW'(c + 4));
        end
    end

    // Per-channel operands, pipelined sum and error status
    for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
        logic [DW-1:0]        op_a;
        logic [DW-1:0]        op_b;
        logic [DW-1:0]        sum_s1;
        logic [DW-1:0]        sum;
        logic [ERR_WIDTH-1:0] flags;
        logic [CNT_WIDTH-1:0] cnt;
        logic [ERR_WIDTH-1:0] err_c;
        logic                 ev_c;
        logic                 wr_c;
        logic                 wr_st_c;
        logic [ERR_WIDTH-1:0] clr_flags_c;
        logic                 clr_cnt_c;
        logic [DW-1:0]        rd_c;

        assign err_c       = err_in[c*ERR_WIDTH +: ERR_WIDTH];
        assign ev_c        = |err_c;
        assign wr_c        = cpu_wr & ch_hit_c[c] & wr_unlock_c;
        assign wr_st_c     = wr_c & (cpu_wr_addr[1:0] == 2'd3);
        assign clr_flags_c = wr_st_c ? cpu_data_in[ERR_WIDTH-1:0] : '0;
        assign clr_cnt_c   = wr_st_c & cpu_data_in[31];

        always_ff @(posedge clks or posedge reset) begin
            if (reset) begin
                op_a   <= '0;
                op_b   <= '0;
                sum_s1 <= '0;
                sum    <= '0;
                flags  <= '0;
                cnt    <= '0;
            end else begin
                if (wr_c && cpu_wr_addr[1:0] == 2'd0) op_a <= cpu_data_in;
                if (wr_c && cpu_wr_addr[1:0] == 2'd1) op_b <= cpu_data_in;
                sum_s1 <= op_a + op_b;
                sum    <= sum_s1;
                // New events win over a same-cycle W1C clear
                flags  <= (flags & ~clr_flags_c) | err_c;
                if (clr_cnt_c) begin
                    cnt <= ev_c ? CNT_WIDTH'(1) : '0;
                end else if (ev_c && cnt != '1) begin
                    cnt <= cnt + CNT_WIDTH'(1);
                end
            end
        end

        always_comb begin
            rd_c = '0;
            case (cpu_wr_addr[1:0])
                2'd0:    rd_c = op_a;
                2'd1:    rd_c = op_b;
                2'd2:    rd_c = sum;
                default: begin
                    rd_c[ERR_WIDTH-1:0] = flags;
                    rd_c[31:16]         = 16'(cnt);
                end
            endcase
        end

        assign ch_rd_c[c] = rd_c;
    end

    // Read mux; unmapped addresses return zero
    always_comb begin
        rd_data_c = '0;
        case (cpu_wr_addr)
            A_VER_TIME: rd_data_c = DW'(VER_TIME);
            A_VER_TYPE: rd_data_c = DW'(VER_TYPE);
            A_VLED:     rd_data_c = DW'(ul2sh_vled);
            A_TMOUT:    rd_data_c = DW'(reg_tmout_us_cfg);
            A_SCRATCH:  rd_data_c = ~scratch;
            A_RD_CNT:   rd_data_c = rd_cnt;
            A_NUM_CH:   rd_data_c = DW'(NUM_CH);
`ifdef REG_UL_WR_PROTECT_EN
            A_KEY:      rd_data_c = DW'(wr_unlock_c);
`endif
            default:    rd_data_c = '0;
        endcase
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (ch_hit_c[c]) rd_data_c = ch_rd_c[c];
        end
    end

    // Global registers and registered read port
    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            cpu_data_out     <= '0;
            cpu_rd_vld       <= 1'b0;
            ul2sh_vled       <= '0;
            reg_tmout_us_cfg <= 16'hFFFF;
            scratch          <= '0;
            rd_cnt           <= '0;
`ifdef REG_UL_WR_PROTECT_EN
            key              <= '0;
`endif
        end else begin
            cpu_rd_vld <= cpu_rd;
            if (cpu_rd) begin
                cpu_data_out <= rd_data_c;
                rd_cnt       <= rd_cnt + DW'(1);
            end
            if (cpu_wr) begin
                case (cpu_wr_addr)
                    A_VLED:    ul2sh_vled       <= cpu_data_in[15:0];
                    A_TMOUT:   reg_tmout_us_cfg <= cpu_data_in[15:0];
                    A_SCRATCH: scratch          <= cpu_data_in;
`ifdef REG_UL_WR_PROTECT_EN
                    A_KEY:     key              <= cpu_data_in;
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_ul_bank_mc.sv
// Directed self-checking bench for reg_ul_bank_mc (NUM_CH=4, ERR_WIDTH=2, CNT_WIDTH=4).
module tb_reg_ul_bank_mc;

    logic        clks = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_wr = 1'b0;
    logic [11:0] cpu_wr_addr = '0;
    logic [31:0] cpu_data_in = '0;
    logic        cpu_rd = 1'b0;
    logic [31:0] cpu_data_out;
    logic        cpu_rd_vld;
    logic [15:0] ul2sh_vled;
    logic [15:0] reg_tmout_us_cfg;
    logic [7:0]  err_in = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clks = ~clks;

    reg_ul_bank_mc #(
        .CPU_ADDR_WIDTH(12),
        .CPU_DATA_WIDTH(32),
        .NUM_CH(4),
        .ERR_WIDTH(2),
        .CNT_WIDTH(4)
    ) dut (
        .clks(clks),
        .reset(reset),
        .cpu_wr(cpu_wr),
        .cpu_wr_addr(cpu_wr_addr),
        .cpu_data_in(cpu_data_in),
        .cpu_rd(cpu_rd),
        .cpu_data_out(cpu_data_out),
        .cpu_rd_vld(cpu_rd_vld),
        .ul2sh_vled(ul2sh_vled),
        .reg_tmout_us_cfg(reg_tmout_us_cfg),
        .err_in(err_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clks);
        cpu_wr = 1'b1; cpu_wr_addr = a; cpu_data_in = d;
        @(negedge clks);
        cpu_wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        @(negedge clks);
        cpu_rd = 1'b1; cpu_wr_addr = a;
        @(negedge clks);
        cpu_rd = 1'b0;
        check({tag, "_vld"}, 32'(cpu_rd_vld), 32'd1);
        check(tag, cpu_data_out, exp);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clks);
        check("rst_data_out", cpu_data_out, 32'h0);
        check("rst_rd_vld", 32'(cpu_rd_vld), 32'h0);
        check("rst_vled", 32'(ul2sh_vled), 32'h0);
        check("rst_tmout", 32'(reg_tmout_us_cfg), 32'h0000_FFFF);
        reset = 1'b0;

        // Version registers and read-valid pulse width
        rd_chk("ver_time", 12'h000, 32'h2018_0301);
        @(negedge clks);
        check("vld_pulse", 32'(cpu_rd_vld), 32'h0);
        check("data_hold", cpu_data_out, 32'h2018_0301);
        rd_chk("ver_type", 12'h001, 32'h00D3_0007);
        rd_chk("tmout_rst", 12'h003, 32'h0000_FFFF);
        rd_chk("num_ch", 12'h006, 32'd4);

`ifdef REG_UL_WR_PROTECT_EN
        wr(12'h010, 32'd7);
        rd_chk("locked_opa", 12'h010, 32'd0);
        rd_chk("key_locked", 12'h00F, 32'd0);
        wr(12'h00F, 32'h5A5A_A5A5);
        wr(12'h010, 32'd7);
        rd_chk("unlocked_opa", 12'h010, 32'd7);
        rd_chk("key_unlocked", 12'h00F, 32'd1);
        wr(12'h010, 32'd0);
`else
        rd_chk("key_unmapped", 12'h00F, 32'd0);
`endif

        // Channel 2 adder with wraparound
        wr(12'h018, 32'hFFFF_FFFF);
        wr(12'h019, 32'h0000_0002);
        repeat (2) @(negedge clks);
        rd_chk("ch2_sum", 12'h01A, 32'h0000_0001);
        rd_chk("ch2_opa", 12'h018, 32'hFFFF_FFFF);

        // Scratch, vled, tmout
        wr(12'h004, 32'h0000_1234);
        rd_chk("scratch_inv", 12'h004, 32'hFFFF_EDCB);
        wr(12'h002, 32'hABCD_5A3C);
        check("vled_port", 32'(ul2sh_vled), 32'h0000_5A3C);
        rd_chk("vled_rd", 12'h002, 32'h0000_5A3C);
        wr(12'h003, 32'h0000_0010);
        check("tmout_port", 32'(reg_tmout_us_cfg), 32'h0000_0010);

        // Read-only and unmapped writes ignored; unmapped reads return 0
        wr(12'h000, 32'hDEAD_BEEF);
        rd_chk("ver_ro", 12'h000, 32'h2018_0301);
        wr(12'h020, 32'hDEAD_BEEF);
        rd_chk("out_of_range", 12'h020, 32'h0);
        rd_chk("unmapped_0ff", 12'h0FF, 32'h0);

        // Channel 1 error flags and counter
        @(negedge clks);
        err_in = 8'h08;
        repeat (3) @(negedge clks);
        err_in = 8'h00;
        rd_chk("ch1_status3", 12'h017, 32'h0003_0002);
        rd_chk("ch0_status", 12'h013, 32'h0);
        @(negedge clks);
        cpu_wr = 1'b1; cpu_wr_addr = 12'h017; cpu_data_in = 32'h2; err_in = 8'h08;
        @(negedge clks);
        cpu_wr = 1'b0; err_in = 8'h00;
        rd_chk("set_wins", 12'h017, 32'h0004_0002);
        wr(12'h017, 32'h8000_0002);
        rd_chk("ch1_clear", 12'h017, 32'h0);
        @(negedge clks);
        cpu_wr = 1'b1; cpu_wr_addr = 12'h017; cpu_data_in = 32'h8000_0000; err_in = 8'h08;
        @(negedge clks);
        cpu_wr = 1'b0; err_in = 8'h00;
        rd_chk("clr_inc", 12'h017, 32'h0001_0002);

        // Channel 3 counter saturation
        @(negedge clks);
        err_in = 8'h40;
        repeat (20) @(negedge clks);
        err_in = 8'h00;
        rd_chk("ch3_sat", 12'h01F, 32'h000F_0001);

        // Same-address read and write: read returns the old value
        @(negedge clks);
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_wr_addr = 12'h011; cpu_data_in = 32'h55;
        @(negedge clks);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        check("rw_old", cpu_data_out, 32'h0);
        rd_chk("rw_new", 12'h011, 32'h55);

        // Reset during a pending read
        @(negedge clks);
        cpu_rd = 1'b1; cpu_wr_addr = 12'h000;
        @(posedge clks);
        #1;
        reset = 1'b1; cpu_rd = 1'b0;
        @(negedge clks);
        check("mid_rst_vld", 32'(cpu_rd_vld), 32'h0);
        check("mid_rst_data", cpu_data_out, 32'h0);
        check("mid_rst_vled", 32'(ul2sh_vled), 32'h0);
        check("mid_rst_tmout", 32'(reg_tmout_us_cfg), 32'h0000_FFFF);
        repeat (2) @(negedge clks);
        reset = 1'b0;

        // Post-reset contents and read counter
        rd_chk("rd_cnt0", 12'h005, 32'd0);
        rd_chk("scratch_rst", 12'h004, 32'hFFFF_FFFF);
        rd_chk("ch1_status_rst", 12'h017, 32'h0);
        rd_chk("ch2_sum_rst", 12'h01A, 32'h0);
        rd_chk("ch0_opb_rst", 12'h011, 32'h0);
        rd_chk("rd_cnt5", 12'h005, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
